ula_divider_seq: RTL

//   Iterative restoring divider that completes the ULA arithmetic set alongside add/sub/and/or.

---
 rtl/ula_pkg.sv | 10 +
 rtl/ula_div_step.sv | 30 +++
 rtl/ula_divider_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared ULA types and widths for the multi-cycle divider.
package ula_pkg;
  localparam int ULA_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } ula_div_state_t;
endpackage

// File: rtl/ula_div_step.sv
// One combinational restoring-division step: shift {r,q} left, trial-subtract d, keep or restore.
// Zero latency; no handshake.
module ula_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;
  logic             borrow_out;

  always_comb begin
    shifted = {r, q[WIDTH-1]};
    borrow  = '0;
    diff    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]       = shifted[i] ^ d[i] ^ borrow[i];
      borrow[i+1]   = (~shifted[i] & d[i]) | (~(shifted[i] ^ d[i]) & borrow[i]);
    end
    // Top bit of the shifted remainder has no divisor bit beneath it.
    borrow_out = ~shifted[WIDTH] & borrow[WIDTH];
    r_next     = borrow_out ? shifted[WIDTH-1:0] : diff;
    q_next     = {q[WIDTH-2:0], ~borrow_out};
  end
endmodule

// File: rtl/ula_divider_seq.sv
// Iterative restoring divider, one quotient bit per clock; DONE pulses WIDTH+1 cycles after START.
// No backpressure: START while busy is dropped. Define ULA_DIV_SIGNED_EN for two's-complement operands.
module ula_divider_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH + 1);

  ula_div_state_t   state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  ula_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_step),
    .q_next (q_step)
  );

`ifdef ULA_DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Divide magnitudes; a zero divisor keeps the all-ones quotient unsigned-style.
  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fix = (neg_q && (d_reg != '0)) ? -q_step : q_step;
    r_fix = neg_r ? -r_step : r_step;
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fix = q_step;
    r_fix = r_step;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
`ifdef ULA_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_reg <= '0;
            q_reg <= a_mag;
            d_reg <= b_mag;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= DIV_RUN;
`ifdef ULA_DIV_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DIV_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_fix;
            remainder <= r_fix;
            div0      <= (d_reg == '0);
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
